// File: rtl/a51_session_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : a51_pkg
//  Purpose  : Shared constants and state encoding for the A5/1 session
//             sequencer and its phase counter.
//  Revision : 1.0  initial release
// ============================================================================
package a51_pkg;

    localparam int KEY_BITS   = 64;
    localparam int FRAME_BITS = 22;
    localparam int KF_BITS    = KEY_BITS + FRAME_BITS;
    localparam int MIX_CYCLES = 100;
    localparam int KS_BITS    = 224;
    localparam int N_BYTES    = KS_BITS / 8;
    localparam int CNT_W      = 9;

    // Session phases, in the order a session walks through them
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MIX  = 3'd2,
        GEN  = 3'd3,
        EMIT = 3'd4,
        DONE = 3'd5
    } state_t;

endpackage : a51_pkg
`default_nettype wire

// File: rtl/a51_session_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : a51_session_ctrl_if
//  Purpose  : Ciphertext byte handshake towards the LCD writer.
//  Revision : 1.0  initial release
// ============================================================================
interface a51_session_ctrl_if;

    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;

    modport master (output char_valid, output char_data, input char_ready);
    modport slave  (input char_valid, input char_data, output char_ready);

endinterface : a51_session_ctrl_if
`default_nettype wire

// File: rtl/a51_session_ctrl_phase_counter.sv
`default_nettype none
// ============================================================================
//  Module   : a51_phase_counter
//  Purpose  : Phase length counter with synchronous clear and a terminal
//             flag that is high while the count equals limit-1.
//  Revision : 1.0  initial release
// ============================================================================
module a51_phase_counter
    import a51_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    // Count enabled cycles; clear has priority so a new phase starts at 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_last = (r_cnt == (i_limit - 1'b1));

endmodule : a51_phase_counter
`default_nettype wire

// File: rtl/a51_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : a51_session_ctrl
//  Purpose  : A5/1 session sequencer. Latches key+frame and message on a
//             start edge, steps the keygen through load/mix/output phases,
//             captures the keystream and hands out ciphertext bytes.
//  Revision : 1.0  initial release
// ============================================================================
module a51_session_ctrl
    import a51_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [KF_BITS-1:0] keyframe,
    input  logic [KS_BITS-1:0] msg,
    input  logic               ks_bit,
    output logic               load_bit,
    output logic               stage_load,
    output logic               stage_mix,
    output logic               stage_out,
    output logic               busy,
    output logic               done,
    a51_session_ctrl_if.master bus
);

    state_t             r_state;
    logic               r_start_f1;
    logic               r_start_f2;
    // Shadows are consumed LSB-first by shifting, so bit/byte 0 is always
    // at the bottom; the keystream shifts in from the top so the first
    // captured bit ends up at position 0.
    logic [KF_BITS-1:0] r_kf_shadow;
    logic [KS_BITS-1:0] r_msg_shadow;
    logic [KS_BITS-1:0] r_ks_reg;

    logic               w_start_edge;
    logic               w_go;
    logic               w_xfer;
    logic               w_cnt_en;
    logic               w_last;
    logic               w_phase_end;
    logic               w_cnt_clr;
    logic [CNT_W-1:0]   w_limit;

    assign w_start_edge = r_start_f1 & ~r_start_f2;
    assign w_go         = (r_state == IDLE) & w_start_edge & ~abort;
    assign w_xfer       = (r_state == EMIT) & bus.char_ready;
    assign w_cnt_en     = (r_state == LOAD) | (r_state == MIX) |
                          (r_state == GEN)  | w_xfer;
    assign w_phase_end  = w_cnt_en & w_last;
    assign w_cnt_clr    = w_phase_end | w_go | abort;

    // Phase length for the current state; EMIT counts transfers, not cycles
    always_comb begin
        w_limit = CNT_W'(1);
        case (r_state)
            LOAD:    w_limit = CNT_W'(KF_BITS);
            MIX:     w_limit = CNT_W'(MIX_CYCLES);
            GEN:     w_limit = CNT_W'(KS_BITS);
            EMIT:    w_limit = CNT_W'(N_BYTES);
            default: w_limit = CNT_W'(1);
        endcase
    end

    a51_phase_counter u_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_cnt_clr),
        .i_en    (w_cnt_en),
        .i_limit (w_limit),
        .o_last  (w_last)
    );

    // Two-flop start synchroniser feeding the rising-edge detector
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_start_f1 <= 1'b0;
            r_start_f2 <= 1'b0;
        end else begin
            r_start_f1 <= start;
            r_start_f2 <= r_start_f1;
        end
    end

    // Session FSM with shadow/keystream datapath; abort beats everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_kf_shadow  <= '0;
            r_msg_shadow <= '0;
            r_ks_reg     <= '0;
        end else if (abort && (r_state != IDLE)) begin
            r_state  <= IDLE;
            r_ks_reg <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_kf_shadow  <= keyframe;
                        r_msg_shadow <= msg;
                        r_state      <= LOAD;
                    end
                end
                LOAD: begin
                    r_kf_shadow <= r_kf_shadow >> 1;
                    if (w_last) r_state <= MIX;
                end
                MIX: begin
                    if (w_last) r_state <= GEN;
                end
                GEN: begin
                    r_ks_reg <= {ks_bit, r_ks_reg[KS_BITS-1:1]};
                    if (w_last) r_state <= EMIT;
                end
                EMIT: begin
                    if (w_xfer) begin
                        r_msg_shadow <= r_msg_shadow >> 8;
                        r_ks_reg     <= r_ks_reg >> 8;
                        if (w_last) r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign stage_load     = (r_state == LOAD);
    assign stage_mix      = (r_state == MIX);
    assign stage_out      = (r_state == GEN);
    assign load_bit       = stage_load & r_kf_shadow[0];
    assign busy           = (r_state != IDLE);
    assign done           = (r_state == DONE);
    assign bus.char_valid = (r_state == EMIT);
    assign bus.char_data  = (r_state == EMIT) ?
                            (r_msg_shadow[7:0] ^ r_ks_reg[7:0]) : 8'h00;

endmodule : a51_session_ctrl
`default_nettype wire

// File: tb/tb_a51_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_a51_session_ctrl
//  Purpose  : Self-checking bench for the A5/1 session sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_a51_session_ctrl;

    localparam int KF     = 86;
    localparam int KS     = 224;
    localparam int NB     = 28;
    localparam int T_MIX  = 2 + 86;
    localparam int T_GEN  = T_MIX + 100;
    localparam int T_EMIT = T_GEN + 224;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          ks_bit = 1'b0;
    logic [KF-1:0] keyframe = '0;
    logic [KS-1:0] msg = '0;
    logic          load_bit, stage_load, stage_mix, stage_out, busy, done;

    int checks = 0;
    int errors = 0;

    a51_session_ctrl_if bus ();

    always #5 clk = ~clk;

    a51_session_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .keyframe   (keyframe),
        .msg        (msg),
        .ks_bit     (ks_bit),
        .load_bit   (load_bit),
        .stage_load (stage_load),
        .stage_mix  (stage_mix),
        .stage_out  (stage_out),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // {busy, stage_load, stage_mix, stage_out, load_bit, char_valid, done}
    function automatic logic [6:0] outs();
        return {busy, stage_load, stage_mix, stage_out, load_bit, bus.char_valid, done};
    endfunction

    function automatic logic [KS-1:0] rnd_ks();
        logic [KS-1:0] v;
        for (int i = 0; i < KS / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [KF-1:0] rnd_kf();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[KF-1:0];
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_gap();
        start = 1'b0;
        repeat (3) cyc();
    endtask

    // One full session from the start edge. ks holds the keystream bits in
    // the order the keygen delivers them (bit i = i-th output bit).
    // rmode: 0 ready tied high, 1 ready pattern 0,0,1 per byte, 2 random.
    task automatic run_session(input logic [KF-1:0] kf, input logic [KS-1:0] m,
                               input logic [KS-1:0] ks, input int rmode,
                               input bit toggle);
        logic [7:0] expb [NB];
        logic [6:0] e;
        int  c, k, pat;
        bit  fin, e_load, e_mix, e_gen, e_emit, e_done, e_lb, rdy;
        for (int i = 0; i < NB; i++) expb[i] = m[8*i +: 8] ^ ks[8*i +: 8];
        keyframe = kf;
        msg      = m;
        bus.char_ready = 1'b0;
        start = 1'b1;
        c = 0; k = 0; pat = 0; fin = 1'b0;
        while (!fin && c < 3000) begin
            cyc();
            c++;
            // Input changes after the start edge must not disturb the session
            if (c == 5) begin
                keyframe = rnd_kf();
                msg      = rnd_ks();
            end
            e_load = (c >= 2) && (c < T_MIX);
            e_mix  = (c >= T_MIX) && (c < T_GEN);
            e_gen  = (c >= T_GEN) && (c < T_EMIT);
            e_emit = (c >= T_EMIT) && (k < NB);
            e_done = (k == NB);
            e_lb   = 1'b0;
            if (e_load) e_lb = kf[c-2];
            e = {(c >= 2), e_load, e_mix, e_gen, e_lb, e_emit, e_done};
            chk("outs", 32'(outs()), 32'(e));
            if (e_emit) chk("byte", 32'(bus.char_data), 32'(expb[k]));
            if (e_done) fin = 1'b1;
            // Drive inputs for the coming edge
            if (e_gen) ks_bit = ks[c-T_GEN];
            else       ks_bit = 1'($urandom);
            if (rmode == 0)                 rdy = 1'b1;
            else if (rmode == 1 && e_emit)  rdy = ((pat % 3) == 2);
            else                            rdy = 1'($urandom);
            bus.char_ready = rdy;
            if (e_emit) begin
                pat++;
                if (rdy) k++;
            end
            if (toggle && c == 250) start = 1'b0;
            if (toggle && c == 256) start = 1'b1;
        end
        if (!fin) chk("timeout", 32'd0, 32'd1);
        cyc();
        chk("post_done", 32'(outs()), 32'd0);
    endtask

    initial begin
        int c;
        bus.char_ready = 1'b0;
        // Reset state
        repeat (3) cyc();
        chk("rst_outs", 32'(outs()), 32'd0);
        chk("rst_data", 32'(bus.char_data), 32'd0);
        reset = 1'b1;
        repeat (2) cyc();
        chk("idle_outs", 32'(outs()), 32'd0);

        // msg 0 with ks all ones -> 0xFF bytes; only keyframe bit 0 set
        run_session(86'h1, '0, {KS{1'b1}}, 0, 1'b0);
        idle_gap();
        // msg A5 with ks zero -> A5 bytes; only frame bit 64 set
        run_session(86'h1 << 64, {NB{8'hA5}}, '0, 0, 1'b0);
        idle_gap();
        // Alternating keystream 1,0,1,0 with 0,0,1 backpressure -> 0x55 bytes
        run_session(rnd_kf(), '0, {56{4'h5}}, 1, 1'b0);
        idle_gap();
        // Random data, random ready, start toggled during GEN
        run_session(rnd_kf(), rnd_ks(), rnd_ks(), 2, 1'b1);

        // start left high after DONE must not retrigger
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("hold_idle", 32'(outs()), 32'd0);
        end

        // Abort during MIX
        idle_gap();
        keyframe = rnd_kf();
        start = 1'b1;
        for (c = 1; c <= 120; c++) cyc();
        chk("in_mix", 32'(stage_mix), 32'd1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_outs", 32'(outs()), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("abort_idle", 32'(outs()), 32'd0);
        end

        // Abort coinciding with a start edge in IDLE wins
        idle_gap();
        start = 1'b1;
        abort = 1'b1;
        repeat (3) cyc();
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("abort_start", 32'(busy), 32'd0);
        end
        idle_gap();
        run_session(rnd_kf(), rnd_ks(), rnd_ks(), 2, 1'b0);

        // Asynchronous reset during EMIT
        idle_gap();
        bus.char_ready = 1'b0;
        start = 1'b1;
        for (c = 1; c <= T_EMIT + 3; c++) cyc();
        chk("emit_valid", 32'(bus.char_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_valid", 32'(bus.char_valid), 32'd0);
        chk("rst_async_outs", 32'(outs()), 32'd0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) cyc();
        run_session(rnd_kf(), rnd_ks(), rnd_ks(), 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_a51_session_ctrl
`default_nettype wire

// File: doc/a51_session_ctrl.md
Name: a51_session_ctrl

Overview:
- Session sequencer for the A5/1 encrypt/decrypt path.
- On a rising edge of the start switch, it latches the 86-bit key+frame and message, then drives the keygen through its phases: serial load (64 key bits + 22 frame bits), 100-cycle mixing, and 224-cycle keystream capture.
- It XORs the captured keystream with the message and hands the 28 ciphertext bytes to the LCD writer over a valid/ready handshake.
- It replaces the ad-hoc counter/edge-detect glue around the keygen and the 224-bit output register.

Parameters:
- KF_BITS, 86, key+frame length; the first 64 bits are key, the rest are frame.
- MIX_CYCLES, 100, irregular-clocking warm-up cycles.
- KS_BITS, 224, keystream/message length in bits; must be a multiple of 8.
- CNT_W, 9, phase counter width; must satisfy 2^CNT_W > max(KF_BITS, MIX_CYCLES, KS_BITS).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  level from flip switch; a rising edge begins a session.
- abort  in  1  synchronous; forces the block back to IDLE.
- keyframe  in  KF_BITS  key (bits 63:0) and frame (bits 85:64).
- msg  in  KS_BITS  plaintext or ciphertext from the data store.
- ks_bit  in  1  keygen output bit; combinational from LFSR state.
- load_bit  out  1  serial key/frame bit, XORed into all three LFSR feedbacks.
- stage_load  out  1  regular-clock all LFSRs and XOR in load_bit.
- stage_mix  out  1  majority clocking; output discarded.
- stage_out  out  1  majority clocking; ks_bit valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final byte transfer.
- char_valid  out  1  ciphertext byte available.
- char_data  out  8  ciphertext byte.
- char_ready  in  1  LCD writer accepts the byte.

Behaviour:
- Reset
  - While reset=0: state IDLE, counters 0, shadow registers 0, edge-detect flops 0.
  - All outputs 0 while reset=0, including on mid-session assertion; no partial byte is emitted.
- Start detection
  - start passes through two flops, f1 then f2; edge = f1 & ~f2.
  - The edge is acted on only in IDLE and ignored in all other states.
  - On the edge: keyframe and msg are copied into shadow registers, the counter clears, and the state goes to LOAD.
  - Result: stage_load is high starting on the 2nd clk edge after start rises.
- FSM: IDLE -> LOAD -> MIX -> GEN -> EMIT -> DONE -> IDLE.
  - LOAD (KF_BITS cycles, cnt 0..85): stage_load=1, load_bit=kf_shadow[cnt]. Bit 0 goes first: key 0..63, then frame 64..85.
  - MIX (MIX_CYCLES cycles): stage_mix=1.
  - GEN (KS_BITS cycles): stage_out=1; ks_bit is captured into ks_reg[cnt] at each clk edge, so the first keystream bit lands in ks_reg[0].
  - EMIT (KS_BITS/8 transfers, byte index k=0..27): char_valid=1, char_data = msg_shadow[8k+7:8k] ^ ks_reg[8k+7:8k].
  - DONE (1 cycle): done=1, then IDLE.
  - Each phase leaves on the edge where cnt == length-1. The counter clears on every phase entry.
- Phase outputs are Moore (decoded from state/counter registers) and mutually exclusive; exactly one of stage_load, stage_mix, stage_out is high in LOAD, MIX, GEN.
- Handshake
  - A transfer occurs on a clk edge with char_valid & char_ready.
  - char_data is held stable while char_valid=1 and char_ready=0.
  - char_ready is ignored when char_valid=0. There is no timeout.
  - The 28th transfer moves the state to DONE.
- Abort
  - abort=1 on any clk edge in a non-IDLE state puts the block in IDLE on that edge.
  - Outputs are 0 on the next cycle and ks_reg is cleared.
  - If abort and a start edge occur together in IDLE, abort wins and no session starts.
- Restart
  - A new session needs start to fall and rise again; start held high after DONE does not retrigger.
  - Shadow registers make the session immune to keyframe/msg changes after the start edge.
- Total latency from start edge to first char_valid: 2 + 86 + 100 + 224 = 412 cycles.

Decomposition:
- Shared package a51_pkg:
  - state enum (IDLE, LOAD, MIX, GEN, EMIT, DONE);
  - localparams KF_BITS, KEY_BITS=64, FRAME_BITS=22, MIX_CYCLES, KS_BITS.
- One sub-module, a51_phase_counter:
  - CNT_W up-counter with sync clear and a terminal-compare output (cnt == limit-1);
  - limit is selected by state.
- The edge detector stays inline.

Test Plan:
- Nominal timing: reset released, start rises at cycle 0.
  - stage_load high for cycles 2..87, stage_mix 88..187, stage_out 188..411.
  - char_valid rises at cycle 412; busy is high 2..end.
- Data path, with char_ready tied 1:
  - keyframe=0 and msg=0, ks_bit tied 1: 28 bytes of 0xFF on consecutive cycles, done pulses one cycle after the last byte.
  - msg = {28{8'hA5}}, ks_bit tied 0: 28 bytes of 0xA5.
- Load ordering: keyframe = 86'h1 (only bit 0 set) -> load_bit=1 only in the first LOAD cycle. With bit 64 set -> load_bit=1 only in LOAD cycle 64.
- Backpressure: char_ready toggles 0,0,1 repeatedly -> each byte is held stable for 3 cycles, exactly 28 transfers, no byte duplicated or skipped. Check byte order k=0..27 against the ks_reg pattern from a known alternating ks_bit (1,0,1,0...) -> bytes 0x55.
- Abort/reset mid-session:
  - abort asserted during MIX -> IDLE next cycle, all outputs 0.
  - Async reset low during EMIT -> char_valid drops immediately without waiting for clk.
  - A subsequent start edge runs a full, correct session.
- Retrigger/ignore:
  - start toggled during GEN -> no effect.
  - start held high through DONE -> stays IDLE until start falls and rises again.
